// File: rtl/tcdm_spm_pkg.sv
// Shared types, address-field helpers and parameter-check constants for the banked TCDM scratchpad.
package tcdm_spm_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int unsigned MIN_RESP_LAT = 1;
  localparam int unsigned MAX_RESP_LAT = 4;

  function automatic int unsigned bank_off(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int unsigned row_off(input int unsigned data_width,
                                          input int unsigned num_banks);
    return $clog2(data_width / 8) + $clog2(num_banks);
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/tcdm_spm_bank_arb.sv
// Single-bank arbiter: fixed priority (lowest port wins) or round-robin starting at the owned pointer.
module tcdm_spm_bank_arb
  import tcdm_spm_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  arb_mode_e            mode_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0] r_ptr;
  logic          w_found;
  int unsigned   w_win;
  int unsigned   w_idx;

  // Search starts at the pointer in RR mode, at port 0 otherwise; no grant while in reset.
  always_comb begin
    w_found = 1'b0;
    w_win   = 0;
    w_idx   = 0;
    gnt_o   = '0;
    if (!rst_i) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        w_idx = (mode_i == ARB_RR) ? (32'(r_ptr) + k) % NUM_PORTS : k;
        if (!w_found && |(req_i & (NUM_PORTS'(1) << w_idx))) begin
          w_found = 1'b1;
          w_win   = w_idx;
        end
      end
    end
    if (w_found) gnt_o = NUM_PORTS'(1) << w_win;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= PW'((w_win + 1) % NUM_PORTS);
    end
  end

endmodule

// File: rtl/tcdm_banked_spm.sv
// Word-interleaved multi-bank scratchpad with per-bank arbitration, fixed response latency and contention counters.
module tcdm_banked_spm
  import tcdm_spm_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_ROWS   = 1024,
  parameter int unsigned RESP_LAT   = 1,
  parameter int unsigned ARB_MODE   = 1,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_PORTS-1:0]                  req_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  add_i,
  input  logic [NUM_PORTS-1:0]                  wen_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
  output logic [NUM_PORTS-1:0]                  gnt_o,
  output logic [NUM_PORTS-1:0]                  vld_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
  input  logic                                  cnt_clear_i,
  output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]   stall_cnt_o,
  output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]   gnt_cnt_o
);

  localparam int unsigned BE_W     = DATA_WIDTH / 8;
  localparam int unsigned BANK_OFF = bank_off(DATA_WIDTH);
  localparam int unsigned ROW_OFF  = row_off(DATA_WIDTH, NUM_BANKS);
  localparam int unsigned BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned RW       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam arb_mode_e   MODE     = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;

  if (NUM_PORTS < 1) begin : g_chk_ports
    $error("NUM_PORTS must be at least 1");
  end
  if (!is_pow2(NUM_BANKS)) begin : g_chk_banks
    $error("NUM_BANKS must be a power of two");
  end
  if (!is_pow2(NUM_ROWS)) begin : g_chk_rows
    $error("NUM_ROWS must be a power of two");
  end
  if (RESP_LAT < MIN_RESP_LAT || RESP_LAT > MAX_RESP_LAT) begin : g_chk_lat
    $error("RESP_LAT must be in 1..4");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
    $error("DATA_WIDTH must be a multiple of 8");
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic ev);
    return (ev && (v != '1)) ? v + 1'b1 : v;
  endfunction

  logic [NUM_PORTS-1:0][BW-1:0] w_bank;
  logic [NUM_PORTS-1:0][RW-1:0] w_row;
  logic [NUM_PORTS-1:0]         w_bank_req [NUM_BANKS];
  logic [NUM_PORTS-1:0]         w_bank_gnt [NUM_BANKS];
  logic [DATA_WIDTH-1:0]        w_bank_rdata [NUM_BANKS];

  // Masking instead of slicing keeps the zero-width bank field of a single-bank build legal.
  always_comb begin
    w_bank = '0;
    w_row  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      w_bank[p] = BW'((add_i[p] >> BANK_OFF) & ADDR_WIDTH'(NUM_BANKS - 1));
      w_row[p]  = RW'((add_i[p] >> ROW_OFF) & ADDR_WIDTH'(NUM_ROWS - 1));
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      w_bank_req[b] = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        w_bank_req[b][p] = req_i[p] && (32'(w_bank[p]) == b);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      gnt_o = gnt_o | w_bank_gnt[b];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [NUM_ROWS];
    logic                  w_we;
    logic [RW-1:0]         w_brow;
    logic [DATA_WIDTH-1:0] w_bwdata;
    logic [BE_W-1:0]       w_bbe;

    tcdm_spm_bank_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .mode_i (MODE),
      .req_i  (w_bank_req[b]),
      .gnt_o  (w_bank_gnt[b])
    );

    always_comb begin
      w_we     = 1'b0;
      w_brow   = '0;
      w_bwdata = '0;
      w_bbe    = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (w_bank_gnt[b][p]) begin
          w_we     = !wen_i[p];
          w_brow   = w_row[p];
          w_bwdata = wdata_i[p];
          w_bbe    = be_i[p];
        end
      end
    end

    assign w_bank_rdata[b] = r_mem[w_brow];

    always_ff @(posedge clk_i) begin
      if (w_we) begin
        for (int unsigned i = 0; i < BE_W; i++) begin
          if (w_bbe[i]) r_mem[w_brow][8*i +: 8] <= w_bwdata[8*i +: 8];
        end
      end
    end
  end

  logic [NUM_PORTS-1:0]                 r_vld_pipe   [RESP_LAT];
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_rdata_pipe [RESP_LAT];
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  r_stall_cnt;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  r_gnt_cnt;

  // Response stage boundary: bank read is captured at the grant edge, then shifted RESP_LAT-1 more times.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < RESP_LAT; s++) r_vld_pipe[s] <= '0;
    end else begin
      r_vld_pipe[0] <= gnt_o;
      for (int unsigned s = 1; s < RESP_LAT; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      r_rdata_pipe[0][p] <= (gnt_o[p] && wen_i[p]) ? w_bank_rdata[w_bank[p]] : '0;
    end
    for (int unsigned s = 1; s < RESP_LAT; s++) r_rdata_pipe[s] <= r_rdata_pipe[s-1];
  end

  assign vld_o = r_vld_pipe[RESP_LAT-1];

  // Data stages are not reset, so gate with valid to keep rdata_o at zero when idle.
  always_comb begin
    rdata_o = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (vld_o[p]) rdata_o[p] = r_rdata_pipe[RESP_LAT-1][p];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (rst_i || cnt_clear_i) begin
        r_stall_cnt[p] <= '0;
        r_gnt_cnt[p]   <= '0;
      end else begin
        r_stall_cnt[p] <= sat_inc(r_stall_cnt[p], req_i[p] && !gnt_o[p]);
        r_gnt_cnt[p]   <= sat_inc(r_gnt_cnt[p], gnt_o[p]);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign gnt_cnt_o   = r_gnt_cnt;

endmodule

// File: doc/tcdm_banked_spm.md
# tcdm_banked_spm

Parametrised, word-interleaved, multi-bank scratchpad memory model with NUM_PORTS TCDM master ports and NUM_BANKS single-port banks. It has per-bank arbitration (fixed-priority or round-robin), configurable response latency and per-port contention counters for real-time interference analysis. It sits behind the AXI-to-TCDM converter in test benches and SoC models. It replaces the fixed 4×4, 1-cycle, uninstrumented memory back end.

## Interface
- NUM_PORTS, 4: TCDM master ports (≥1)
- NUM_BANKS, 4: banks; power of two, ≥1
- DATA_WIDTH, 32: word width; multiple of 8
- ADDR_WIDTH, 32: byte address width
- NUM_ROWS, 1024: words per bank; power of two
- RESP_LAT, 1: grant-to-vld cycles; 1..4
- ARB_MODE, 1: 0 = fixed priority (lowest port wins), 1 = round-robin
- CNT_WIDTH, 32: contention counter width
- Reset rule (already decided): one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_i  in  NUM_PORTS  request per port
- add_i  in  NUM_PORTS×ADDR_WIDTH  byte address
- wen_i  in  NUM_PORTS  1 = read, 0 = write
- wdata_i  in  NUM_PORTS×DATA_WIDTH  write data
- be_i  in  NUM_PORTS×DATA_WIDTH/8  byte enables, writes only
- gnt_o  out  NUM_PORTS  combinational grant, same cycle as req
- vld_o  out  NUM_PORTS  response valid, for reads and writes
- rdata_o  out  NUM_PORTS×DATA_WIDTH  read data; 0 on write responses
- cnt_clear_i  in  1  zero all counters
- stall_cnt_o  out  NUM_PORTS×CNT_WIDTH  cycles with req_i && !gnt_o
- gnt_cnt_o  out  NUM_PORTS×CNT_WIDTH  granted requests

## Operation
- Address decode:
  - OFF = log2(DATA_WIDTH/8).
  - bank = add[OFF +: log2 NUM_BANKS].
  - row = add[OFF+log2 NUM_BANKS +: log2 NUM_ROWS].
  - Higher bits are ignored, so addresses alias (wrap) every NUM_BANKS·NUM_ROWS words.
  - With NUM_BANKS = 1, the bank field is zero-width.
- Arbitration is independent per bank. At most one grant per bank per cycle, so ports hitting distinct banks are all granted.
- ARB_MODE 0: lowest-index requesting port wins.
- ARB_MODE 1:
  - Each bank has a pointer, reset to 0.
  - The winner is the first requester at or after the pointer, searching modulo NUM_PORTS.
  - On grant, pointer := winner+1 mod NUM_PORTS. The pointer is unchanged when there is no grant.
- A granted write updates only the enabled bytes at the edge ending the grant cycle.
- A granted read samples the row at that same edge. Read-after-write in the next cycle returns the new data.
- Response path:
  - Per-port shift pipeline of depth RESP_LAT carrying {vld, rdata}.
  - A grant in cycle t gives vld_o in cycle t+RESP_LAT, for one cycle per grant.
  - Back-to-back grants give back-to-back vld_o pulses, in order.
- Counters:
  - Each port's counters increment per qualifying cycle and saturate at all-ones.
  - cnt_clear_i takes priority over increment: the counter reads 0 next cycle, and the current-cycle event is not counted.
- Memory array is not reset. Simulation initialises it to 0.

## Timing
- Reset values: vld_o 0, rdata_o 0, all counters 0, RR pointers 0.
- gnt_o is combinational from req_i and the RR state. It is 0 in cycles where rst_i = 1.
- Reset mid-operation discards all in-flight responses: no vld_o in the cycle after reset deasserts. Memory contents are preserved.
- Requesters must hold req_i and its payload stable until granted. The block registers nothing for ungranted requests.
- Minimum latency is RESP_LAT. Worst-case wait under RR is (NUM_PORTS−1) cycles per bank.
- The same port issuing every cycle to a free bank sustains full throughput.

## Structure
- Package tcdm_spm_pkg holds:
  - the arb_mode_e enum (ARB_FIXED, ARB_RR);
  - functions for the bank and row field offsets;
  - parameter-check constants.
- Sub-module tcdm_spm_bank_arb is instantiated once per bank:
  - req vector and mode in;
  - one-hot grant out;
  - owns the RR pointer.
- The top level holds the decode, bank storage arrays, response pipelines and counters.
- Elaboration-time assertions check: NUM_BANKS and NUM_ROWS are powers of two; RESP_LAT is in 1..4; DATA_WIDTH%8 == 0.

## Test plan
- Write 0xDEADBEEF (be = 0xF) at 0x0 on port 0, then read 0x0 → vld_o[0] after RESP_LAT and rdata 0xDEADBEEF. Write with be = 0x2, data 0x0000AA00 → read gives 0xDEADAABEEF-merged value 0xDEADAAEF.
- Four ports read 0x0, 0x4, 0x8, 0xC in the same cycle (4 banks) → all gnt_o = 1 and four vld_o pulses together. Stall counters stay 0.
- Four ports all request 0x10 continuously for 8 cycles with ARB_MODE 1 → grants rotate 0,1,2,3,0,… Each gnt_cnt = 2 and each stall_cnt = 6.
- Same scenario with ARB_MODE 0 → port 0 granted every cycle. Port 3 stall_cnt = 8 and gnt_cnt = 0.
- RESP_LAT = 3 with a read granted at t, rst_i asserted at t+1 for one cycle → no vld_o at t+3. Memory is unchanged, and counters are 0.
- Write to 0x0 then 0x4000 (NUM_ROWS = 1024, 4 banks) → read 0x0 returns the second value (aliasing). With CNT_WIDTH = 4 under forced contention, stall_cnt saturates at 0xF. cnt_clear_i returns it to 0.
